// File: rtl/half_subtractor_pkg.sv
// Shared constants and a reference subtract helper for the half_subtractor_s datapath.
// Nothing in here is timing-related; it is pure elaboration-time and model support.
package half_subtractor_pkg;

  localparam int HS_DEFAULT_WIDTH = 1;
  localparam int HS_MAX_WIDTH     = 64;

  // Returns {borrow, d} in the low width+1 bits; operands must already fit in width bits.
  function automatic logic [HS_MAX_WIDTH:0] hs_sub(input logic [HS_MAX_WIDTH-1:0] a,
                                                   input logic [HS_MAX_WIDTH-1:0] b,
                                                   input int unsigned             width);
    logic [HS_MAX_WIDTH:0] full;
    logic [HS_MAX_WIDTH:0] mask;
    full = {1'b0, a} - {1'b0, b};
    mask = (65'd1 << (width + 1)) - 65'd1;
    return full & mask;
  endfunction

endpackage

// File: rtl/half_subtractor_s_hs_cell.sv
// 1-bit combinational half subtractor: diff = x ^ y, bout = ~x & y.
// Zero latency, no flow control; two of these plus an OR make one ripple stage.
module hs_cell
  import half_subtractor_pkg::*;
(
  input  logic x,
  input  logic y,
  output logic diff,
  output logic bout
);

  assign diff = x ^ y;
  assign bout = ~x & y;

endmodule

// File: rtl/half_subtractor_s.sv
// Registered WIDTH-bit ripple subtractor d = a - b, borrow = (a < b); 1-cycle latency, no backpressure.
// Optional HALF_SUB_VALID_EN adds in_valid/out_valid; results then load only on valid edges.
module half_subtractor_s
  import half_subtractor_pkg::*;
#(
  parameter int WIDTH = HS_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef HALF_SUB_VALID_EN
  input  logic             in_valid,
  output logic             out_valid,
`endif
  output logic [WIDTH-1:0] d,
  output logic             borrow
);

  logic [WIDTH-1:0] diff_n;
  logic [WIDTH:0]   brw;
  logic [WIDTH-1:0] d_d, d_q;
  logic             borrow_d, borrow_q;

  assign brw[0] = 1'b0;

  // Each stage: first cell subtracts b from a, second subtracts the incoming borrow.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic d0, b0, b1;
    hs_cell u_c0 (.x(a[i]), .y(b[i]),   .diff(d0),        .bout(b0));
    hs_cell u_c1 (.x(d0),   .y(brw[i]), .diff(diff_n[i]), .bout(b1));
    assign brw[i+1] = b0 | b1;
  end

`ifdef HALF_SUB_VALID_EN
  logic out_valid_d, out_valid_q;

  always_comb begin
    d_d         = d_q;
    borrow_d    = borrow_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      d_d      = diff_n;
      borrow_d = brw[WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_valid_q <= 1'b0;
    else        out_valid_q <= out_valid_d;
  end

  assign out_valid = out_valid_q;
`else
  always_comb begin
    d_d      = diff_n;
    borrow_d = brw[WIDTH];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q      <= '0;
      borrow_q <= 1'b0;
    end else begin
      d_q      <= d_d;
      borrow_q <= borrow_d;
    end
  end

  assign d      = d_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_half_subtractor_s.sv
// Directed bench for half_subtractor_s at WIDTH=1 and WIDTH=4; HALF_SUB_VALID_EN adds the valid scenario.
// Inputs change on the falling edge, outputs are sampled 1 time unit after the rising edge.
module tb_half_subtractor_s;

  logic       clk;
  logic       rst_n;
  logic       a1, b1;
  logic       d1;
  logic       br1;
  logic [3:0] a4, b4;
  logic [3:0] d4;
  logic       br4;
`ifdef HALF_SUB_VALID_EN
  logic       in_valid;
  logic       ov1, ov4;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  half_subtractor_s #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1),
`ifdef HALF_SUB_VALID_EN
    .in_valid(in_valid), .out_valid(ov1),
`endif
    .d(d1), .borrow(br1)
  );

  half_subtractor_s #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4),
`ifdef HALF_SUB_VALID_EN
    .in_valid(in_valid), .out_valid(ov4),
`endif
    .d(d4), .borrow(br4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a1 = 1'b1; b1 = 1'b0;
    a4 = 4'h3; b4 = 4'h5;
    #1;
    total_cnt++;
    if ({d1, br1, d4, br4} !== 7'b0) $display("FAIL reset_async d1=%b br1=%b d4=%h br4=%b exp all 0", d1, br1, d4, br4);
    else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      tick();
      total_cnt++;
      if ({d1, br1, d4, br4} !== 7'b0) $display("FAIL reset_hold%0d d1=%b br1=%b d4=%h br4=%b exp all 0", i, d1, br1, d4, br4);
      else pass_cnt++;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_w1_truth();
    logic [1:0] vec [4];
    logic [1:0] exp [4];
    vec = '{2'b00, 2'b01, 2'b10, 2'b11};
    exp = '{2'b00, 2'b11, 2'b10, 2'b00};  // {d, borrow}
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      {a1, b1} = vec[i];
      tick();
      total_cnt++;
      if ({d1, br1} !== exp[i]) $display("FAIL w1_ab%b got d,borrow=%b%b exp %b", vec[i], d1, br1, exp[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_w4_back_to_back();
    logic [7:0] vec [7];
    logic [4:0] exp [7];
    // {a,b} -> {borrow,d}, one vector per cycle including the wrap/equal/max boundaries.
    vec = '{8'h35, 8'hF0, 8'h99, 8'h0F, 8'h83, 8'h27, 8'hAA};
    exp = '{5'h1E, 5'h0F, 5'h00, 5'h11, 5'h05, 5'h1B, 5'h00};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      {a4, b4} = vec[i];
      tick();
      total_cnt++;
      if ({br4, d4} !== exp[i]) $display("FAIL w4_ab%h got borrow=%b d=%h exp borrow=%b d=%h", vec[i], br4, d4, exp[i][4], exp[i][3:0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    a4 = 4'h3; b4 = 4'h5;
    a1 = 1'b0; b1 = 1'b1;
    tick();
    total_cnt++;
    if ({br4, d4} !== 5'h1E) $display("FAIL midrst_pre got borrow=%b d=%h exp borrow=1 d=e", br4, d4);
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({d1, br1, d4, br4} !== 7'b0) $display("FAIL midrst_clear d1=%b br1=%b d4=%h br4=%b exp all 0", d1, br1, d4, br4);
    else pass_cnt++;
    a4 = 4'h7; b4 = 4'h2;
    a1 = 1'b1; b1 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total_cnt++;
    if ({br4, d4} !== 5'h05) $display("FAIL midrst_release got borrow=%b d=%h exp borrow=0 d=5", br4, d4);
    else pass_cnt++;
    total_cnt++;
    if ({d1, br1} !== 2'b00) $display("FAIL midrst_release_w1 got d,borrow=%b%b exp 00", d1, br1);
    else pass_cnt++;
  endtask

`ifdef HALF_SUB_VALID_EN
  task automatic test_valid();
    @(negedge clk);
    in_valid = 1'b0;
    a4 = 4'h1; b4 = 4'h2;
    tick();
    total_cnt++;
    if ({br4, d4, ov4} !== 6'b0_0101_0) $display("FAIL valid_hold got borrow=%b d=%h ov=%b exp borrow=0 d=5 ov=0", br4, d4, ov4);
    else pass_cnt++;
    @(negedge clk);
    in_valid = 1'b1;
    tick();
    total_cnt++;
    if ({br4, d4, ov4} !== 6'b1_1111_1) $display("FAIL valid_load got borrow=%b d=%h ov=%b exp borrow=1 d=f ov=1", br4, d4, ov4);
    else pass_cnt++;
  endtask
`endif

  initial begin
`ifdef HALF_SUB_VALID_EN
    in_valid = 1'b1;
`endif
    test_reset();
    test_w1_truth();
    test_w4_back_to_back();
    test_mid_reset();
`ifdef HALF_SUB_VALID_EN
    test_valid();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
